// File: rtl/fill_engine.sv
// Rectangle fill responder: latches two corners and a colour, then emits one pixel write per
// accepted handshake in raster order. Optional screen clipping under `FILL_CLIP_EN.
module fill_engine #(
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 9,
    parameter int COLOR_BITS = 24,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480
) (
    input  logic                  i_clk,
    input  logic                  i_n_rst,
    input  logic                  i_fill_en,
    input  logic [X_BITS-1:0]     i_x_start,
    input  logic [Y_BITS-1:0]     i_y_start,
    input  logic [X_BITS-1:0]     i_x_end,
    input  logic [Y_BITS-1:0]     i_y_end,
    input  logic [COLOR_BITS-1:0] i_fill_color,
    input  logic                  i_wr_ready,
    output logic                  o_wr_en,
    output logic [X_BITS-1:0]     o_wr_x,
    output logic [Y_BITS-1:0]     o_wr_y,
    output logic [COLOR_BITS-1:0] o_wr_data,
    output logic                  o_fill_done,
    output logic                  o_busy
);

`ifdef FILL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam logic [X_BITS-1:0] X_LIM = X_BITS'(SCREEN_W - 1);
    localparam logic [Y_BITS-1:0] Y_LIM = Y_BITS'(SCREEN_H - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StFill, StDone, StHold} state_t;

    state_t                r_state;
    logic [X_BITS-1:0]     r_xa, r_xb, r_xmin, r_xmax;
    logic [Y_BITS-1:0]     r_ya, r_yb, r_ymax;
    logic [COLOR_BITS-1:0] r_color;
    logic                  r_wr_en, r_fill_done, r_busy;
    logic [X_BITS-1:0]     r_wr_x;
    logic [Y_BITS-1:0]     r_wr_y;
    logic [COLOR_BITS-1:0] r_wr_data;

    logic [X_BITS-1:0] w_xmin, w_xmax, w_xmax_c;
    logic [Y_BITS-1:0] w_ymin, w_ymax, w_ymax_c;
    logic              w_skip;

    always_comb begin
        w_xmin   = (r_xa < r_xb) ? r_xa : r_xb;
        w_xmax   = (r_xa < r_xb) ? r_xb : r_xa;
        w_ymin   = (r_ya < r_yb) ? r_ya : r_yb;
        w_ymax   = (r_ya < r_yb) ? r_yb : r_ya;
        w_xmax_c = (CLIP_EN && (w_xmax > X_LIM)) ? X_LIM : w_xmax;
        w_ymax_c = (CLIP_EN && (w_ymax > Y_LIM)) ? Y_LIM : w_ymax;
        // A rectangle starting entirely off-screen produces no writes at all.
        w_skip   = CLIP_EN && ((w_xmin > X_LIM) || (w_ymin > Y_LIM));
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_state     <= StIdle;
            r_xa        <= '0;
            r_xb        <= '0;
            r_ya        <= '0;
            r_yb        <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_ymax      <= '0;
            r_color     <= '0;
            r_wr_en     <= 1'b0;
            r_fill_done <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_x      <= '0;
            r_wr_y      <= '0;
            r_wr_data   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_fill_en) begin
                        r_xa    <= i_x_start;
                        r_xb    <= i_x_end;
                        r_ya    <= i_y_start;
                        r_yb    <= i_y_end;
                        r_color <= i_fill_color;
                        r_busy  <= 1'b1;
                        r_state <= StLoad;
                    end
                end
                StLoad: begin
                    r_xmin    <= w_xmin;
                    r_xmax    <= w_xmax_c;
                    r_ymax    <= w_ymax_c;
                    r_wr_x    <= w_xmin;
                    r_wr_y    <= w_ymin;
                    r_wr_data <= r_color;
                    if (w_skip) begin
                        r_fill_done <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_wr_en <= 1'b1;
                        r_state <= StFill;
                    end
                end
                StFill: begin
                    // Compare before incrementing so an xmax of all-ones never wraps.
                    if (i_wr_ready) begin
                        if (r_wr_x < r_xmax) begin
                            r_wr_x <= r_wr_x + X_BITS'(1);
                        end else if (r_wr_y < r_ymax) begin
                            r_wr_x <= r_xmin;
                            r_wr_y <= r_wr_y + Y_BITS'(1);
                        end else begin
                            r_wr_en     <= 1'b0;
                            r_fill_done <= 1'b1;
                            r_state     <= StDone;
                        end
                    end
                end
                StDone: begin
                    r_fill_done <= 1'b0;
                    r_state     <= StHold;
                end
                StHold: begin
                    if (!i_fill_en) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_wr_en     <= 1'b0;
                    r_fill_done <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign o_wr_en     = r_wr_en;
    assign o_wr_x      = r_wr_x;
    assign o_wr_y      = r_wr_y;
    assign o_wr_data   = r_wr_data;
    assign o_fill_done = r_fill_done;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_fill_engine.sv
// Self-checking bench for fill_engine: directed and randomized fills against a raster-order
// pixel queue model. Honours `FILL_CLIP_EN in the model.
module tb_fill_engine;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        fill_en = 1'b0;
    logic [9:0]  x_start = '0, x_end = '0;
    logic [8:0]  y_start = '0, y_end = '0;
    logic [23:0] fill_color = '0;
    logic        wr_ready = 1'b1;
    logic        wr_en;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [23:0] wr_data;
    logic        fill_done;
    logic        busy;

    int n_assert = 0;
    int n_fail = 0;
    int q_x[$];
    int q_y[$];

    fill_engine #(
        .X_BITS(10), .Y_BITS(9), .COLOR_BITS(24), .SCREEN_W(640), .SCREEN_H(480)
    ) dut (
        .i_clk(clk),
        .i_n_rst(n_rst),
        .i_fill_en(fill_en),
        .i_x_start(x_start),
        .i_y_start(y_start),
        .i_x_end(x_end),
        .i_y_end(y_end),
        .i_fill_color(fill_color),
        .i_wr_ready(wr_ready),
        .o_wr_en(wr_en),
        .o_wr_x(wr_x),
        .o_wr_y(wr_y),
        .o_wr_data(wr_data),
        .o_fill_done(fill_done),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected pixel list: every (x,y) of the normalised (and optionally clipped) rectangle.
    task automatic build_model(input int xs, input int xe, input int ys, input int ye);
        int xmin, xmax, ymin, ymax;
        q_x.delete();
        q_y.delete();
        xmin = (xs < xe) ? xs : xe;
        xmax = (xs < xe) ? xe : xs;
        ymin = (ys < ye) ? ys : ye;
        ymax = (ys < ye) ? ye : ys;
`ifdef FILL_CLIP_EN
        if (xmax > 639) xmax = 639;
        if (ymax > 479) ymax = 479;
        if (xmin > 639 || ymin > 479) return;
`endif
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                q_x.push_back(x);
                q_y.push_back(y);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check({tag, "_wr_x"}, {22'd0, wr_x}, 32'd0);
        check({tag, "_wr_y"}, {23'd0, wr_y}, 32'd0);
        check({tag, "_wr_data"}, {8'd0, wr_data}, 32'd0);
        check({tag, "_done"}, {31'd0, fill_done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles on pixel stall_idx.
    task automatic run_fill(input int xs, input int xe, input int ys, input int ye,
                            input logic [23:0] col, input int mode, input int stall_idx);
        int  idx = 0;
        int  stalls = 0;
        int  n_low = 0;
        int  wr_cycles = 0;
        int  stall_hold = 0;
        int  expn;
        bit  done_seen = 1'b0;
        build_model(xs, xe, ys, ye);
        expn = q_x.size();
        @(negedge clk);
        x_start = 10'(xs);
        x_end = 10'(xe);
        y_start = 9'(ys);
        y_end = 9'(ye);
        fill_color = col;
        fill_en = 1'b1;
        wr_ready = 1'b1;
        @(negedge clk);
        check("load_busy", {31'd0, busy}, 32'd1);
        check("load_wr_en", {31'd0, wr_en}, 32'd0);
        check("load_done", {31'd0, fill_done}, 32'd0);
        for (int c = 0; c < 4000 && !done_seen; c++) begin
            @(negedge clk);
            // Inputs outside IDLE must have no effect.
            x_start = 10'($urandom);
            x_end = 10'($urandom);
            y_start = 9'($urandom);
            y_end = 9'($urandom);
            fill_color = 24'($urandom);
            if (q_x.size() > 0) begin
                check("wr_en", {31'd0, wr_en}, 32'd1);
                check("wr_x", {22'd0, wr_x}, 32'(q_x[0]));
                check("wr_y", {23'd0, wr_y}, 32'(q_y[0]));
                check("wr_data", {8'd0, wr_data}, {8'd0, col});
                check("early_done", {31'd0, fill_done}, 32'd0);
                wr_cycles++;
                if (idx == stall_idx) stall_hold++;
                case (mode)
                    0: wr_ready = 1'b1;
                    1: wr_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (idx == stall_idx && stalls < 3) begin
                            wr_ready = 1'b0;
                            stalls++;
                        end else begin
                            wr_ready = 1'b1;
                        end
                    end
                endcase
                if (wr_ready) begin
                    void'(q_x.pop_front());
                    void'(q_y.pop_front());
                    idx++;
                end else begin
                    n_low++;
                end
            end else begin
                check("done_pulse", {31'd0, fill_done}, 32'd1);
                check("done_wr_en", {31'd0, wr_en}, 32'd0);
                check("done_busy", {31'd0, busy}, 32'd1);
                done_seen = 1'b1;
            end
        end
        if (!done_seen) check("timeout", 32'd0, 32'd1);
        check("wr_cycles", 32'(wr_cycles), 32'(expn + n_low));
        if (mode == 2 && expn > stall_idx) check("stall_hold", 32'(stall_hold), 32'd4);
        wr_ready = 1'b1;
        @(negedge clk);
        check("hold_done", {31'd0, fill_done}, 32'd0);
        check("hold_wr_en", {31'd0, wr_en}, 32'd0);
        check("hold_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("hold_busy2", {31'd0, busy}, 32'd1);
        fill_en = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_wr_en", {31'd0, wr_en}, 32'd0);
    endtask

    initial begin
        int bx, by;
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        check_outputs_zero("reset_held");
        n_rst = 1'b1;
        @(negedge clk);
        check("post_reset_busy", {31'd0, busy}, 32'd0);

        run_fill(3, 4, 5, 6, 24'h123456, 0, -1);
        run_fill(4, 3, 6, 5, 24'h654321, 0, -1);
        run_fill(3, 4, 5, 6, 24'h0F0F0F, 2, 1);
        run_fill(7, 7, 7, 7, 24'hABCDEF, 0, -1);
        run_fill(630, 700, 479, 500, 24'h00FF00, 0, -1);
        run_fill(650, 650, 479, 500, 24'hFF0000, 0, -1);
        run_fill(1023, 1020, 511, 510, 24'h5A5A5A, 1, -1);
        run_fill(0, 0, 0, 0, 24'hFFFFFF, 0, -1);

        for (int i = 0; i < 8; i++) begin
            bx = $urandom_range(0, 1015);
            by = $urandom_range(0, 503);
            run_fill(bx + $urandom_range(0, 8), bx + $urandom_range(0, 8),
                     by + $urandom_range(0, 8), by + $urandom_range(0, 8),
                     24'($urandom), 1, -1);
        end

        // Reset in the middle of a fill aborts immediately.
        @(negedge clk);
        x_start = 10'd10;
        x_end = 10'd20;
        y_start = 9'd10;
        y_end = 9'd20;
        fill_color = 24'hC0FFEE;
        fill_en = 1'b1;
        wr_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("midfill_wr_en", {31'd0, wr_en}, 32'd1);
        n_rst = 1'b0;
        #1;
        check_outputs_zero("abort");
        fill_en = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, fill_done}, 32'd0);
        check("abort_wr_en", {31'd0, wr_en}, 32'd0);

        run_fill(2, 1, 1, 2, 24'h010203, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
